// File: rtl/trap_ctrl_pkg.sv
// trap_pkg: shared constants and types for the machine-mode trap controller.
package trap_pkg;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_MEPC        = 3'd1,
    S_MSTATUS     = 3'd2,
    S_MCAUSE      = 3'd3,
    S_ASSERT      = 3'd4,
    S_MRET_ST     = 3'd5,
    S_MRET_ASSERT = 3'd6
  } state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int CAUSE_ECALL  = 11;
  localparam int CAUSE_EBREAK = 3;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

endpackage

// File: rtl/trap_ctrl_if.sv
// Output bus of the trap controller: pipeline hold, CSR write port, EX redirect.
interface trap_ctrl_if #(parameter int XLEN = 64);
  logic            hold_flag_o;
  logic            csr_we_o;
  logic [11:0]     csr_waddr_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic            int_assert_o;
  logic [XLEN-1:0] int_addr_o;

  modport master (output hold_flag_o, csr_we_o, csr_waddr_o, csr_wdata_o,
                         int_assert_o, int_addr_o);
  modport slave  (input  hold_flag_o, csr_we_o, csr_waddr_o, csr_wdata_o,
                         int_assert_o, int_addr_o);
endinterface

// File: rtl/trap_ctrl_irq_prio_enc.sv
// irq_prio_enc: pending vector -> valid flag and index of the lowest set bit.
module irq_prio_enc #(
  parameter int NUM_IRQ = 4,
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] pend_i,
  output logic               valid_o,
  output logic [IW-1:0]      idx_o
);

  // Scan high to low so the lowest set line is the last (winning) assignment.
  always_comb begin
    valid_o = |pend_i;
    idx_o   = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (pend_i[k]) idx_o = IW'(k);
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer (ECALL/EBREAK, MRET, NUM_IRQ level irqs).
// Writes mepc/mstatus/mcause one per cycle, then redirects EX.
// Optional macro TRAP_VECTORED_EN: vectored mtvec mode for async traps.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int NUM_IRQ       = 4,
  parameter int IRQ_CODE_BASE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        inst_i,
  input  logic [XLEN-1:0]    inst_addr_i,
  input  logic               jump_flag_i,
  input  logic [XLEN-1:0]    jump_addr_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [XLEN-1:0]    csr_mtvec,
  input  logic [XLEN-1:0]    csr_mepc,
  input  logic [XLEN-1:0]    csr_mstatus,
  input  logic [XLEN-1:0]    csr_mie,
  trap_ctrl_if.master        bus
);

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  state_e          state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] vec_q, vec_d;

  logic [NUM_IRQ-1:0] pend;
  logic               irq_vld;
  logic [IW-1:0]      irq_idx;
  logic [XLEN-2:0]    irq_code;
  logic [XLEN-1:0]    tvec_base;
  logic [XLEN-1:0]    irq_vec;
  logic               take_sync, take_mret, take_async, idle;

  // Bits consumed only by some builds or beyond NUM_IRQ.
  logic unused_bits;
  assign unused_bits = ^{csr_mie[XLEN-1:NUM_IRQ], csr_mtvec[1:0]};

  assign pend = irq_i & csr_mie[NUM_IRQ-1:0];

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .pend_i  (pend),
    .valid_o (irq_vld),
    .idx_o   (irq_idx)
  );

  assign idle       = (state_q == S_IDLE);
  assign take_sync  = idle && (inst_i == INST_ECALL || inst_i == INST_EBREAK);
  assign take_mret  = idle && !take_sync && (inst_i == INST_MRET);
  assign take_async = idle && !take_sync && !take_mret && csr_mstatus[MSTATUS_MIE] && irq_vld;

  assign irq_code  = (XLEN-1)'(IRQ_CODE_BASE) + (XLEN-1)'(irq_idx);
  assign tvec_base = {csr_mtvec[XLEN-1:2], 2'b00};

  // Async target: base, or base + 4*code when vectored mode is built in and selected.
  always_comb begin
    irq_vec = tvec_base;
`ifdef TRAP_VECTORED_EN
    if (csr_mtvec[1:0] == 2'b01) irq_vec = tvec_base + {irq_code[XLEN-3:0], 2'b00};
`endif
  end

  // Next-state and trap context capture; requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    vec_d   = vec_q;
    case (state_q)
      S_IDLE: begin
        if (take_sync) begin
          epc_d   = inst_addr_i;
          cause_d = (inst_i == INST_ECALL) ? XLEN'(CAUSE_ECALL) : XLEN'(CAUSE_EBREAK);
          vec_d   = tvec_base;
          state_d = S_MEPC;
        end else if (take_mret) begin
          state_d = S_MRET_ST;
        end else if (take_async) begin
          epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
          cause_d = {1'b1, irq_code};
          vec_d   = irq_vec;
          state_d = S_MEPC;
        end
      end
      S_MEPC:        state_d = S_MSTATUS;
      S_MSTATUS:     state_d = S_MCAUSE;
      S_MCAUSE:      state_d = S_ASSERT;
      S_ASSERT:      state_d = S_IDLE;
      S_MRET_ST:     state_d = S_MRET_ASSERT;
      S_MRET_ASSERT: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // State and latched trap context.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      epc_q   <= '0;
      cause_q <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      vec_q   <= vec_d;
    end
  end

  // Output decode from the state register; stall also covers the acceptance cycle.
  always_comb begin
    bus.hold_flag_o  = !idle || take_sync || take_mret || take_async;
    bus.csr_we_o     = 1'b0;
    bus.csr_waddr_o  = '0;
    bus.csr_wdata_o  = '0;
    bus.int_assert_o = 1'b0;
    bus.int_addr_o   = '0;
    case (state_q)
      S_MEPC: begin
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = CSR_MEPC;
        bus.csr_wdata_o = epc_q;
      end
      S_MSTATUS: begin
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = CSR_MSTATUS;
        bus.csr_wdata_o = csr_mstatus;
        bus.csr_wdata_o[MSTATUS_MPIE] = csr_mstatus[MSTATUS_MIE];
        bus.csr_wdata_o[MSTATUS_MIE]  = 1'b0;
        bus.csr_wdata_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      S_MCAUSE: begin
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = CSR_MCAUSE;
        bus.csr_wdata_o = cause_q;
      end
      S_ASSERT: begin
        bus.int_assert_o = 1'b1;
        bus.int_addr_o   = vec_q;
      end
      S_MRET_ST: begin
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = CSR_MSTATUS;
        bus.csr_wdata_o = csr_mstatus;
        bus.csr_wdata_o[MSTATUS_MIE]  = csr_mstatus[MSTATUS_MPIE];
        bus.csr_wdata_o[MSTATUS_MPIE] = 1'b1;
      end
      S_MRET_ASSERT: begin
        bus.int_assert_o = 1'b1;
        bus.int_addr_o   = csr_mepc;
      end
      default: ;
    endcase
  end

endmodule
